// File: rtl/pyfive_digital_core.sv
// pyfive digital core: SPI-master boot sequencer and interrupt status-frame sender.
// After reset it reads the flash ID and the first boot word over CS0 (quad read),
// then sends a 13-byte status frame on CS1 for each captured interrupt edge.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RST_WAIT | short settle delay after the internal reset releases
// ST_ID_RD    | 0x9F read-ID transaction on CS0, 24-bit ID captured
// ST_BOOT_RD  | CS-high gap, then 0x6B quad-output read of the boot word
// ST_RUN      | idle; start a frame once a flag is pending and the gap is over
// ST_FRAME    | 104-bit status frame on CS1
module pyfive_digital_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwrup_rst_n,
  input  logic        cpu_rst_n,
  input  logic        rtc_clk,
  input  logic [31:0] fuse_mhartid,
  input  logic        ext_irq,
  input  logic        soft_irq,
  output logic        spim_clk,
  output logic        spim_csn0,
  output logic        spim_csn1,
  output logic        spim_csn2,
  output logic        spim_csn3,
  output logic [1:0]  spim_mode,
  input  logic [3:0]  spim_sdi,
  output logic [3:0]  spim_sdo
);

  typedef enum logic [2:0] {
    ST_RST_WAIT,
    ST_ID_RD,
    ST_BOOT_RD,
    ST_RUN,
    ST_FRAME
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_QUAD   = 2'b10;

  logic rst_all_n, rst_meta_q, rst_sync_q;
  logic [2:0] rtc_sync_q, ext_sync_q, soft_sync_q;
  logic rtc_edge, ext_edge, soft_edge;
  logic [31:0] rtc_cnt_q;
  logic pend_ext_q, pend_soft_q, frame_start;

  state_e state_q, state_d;
  logic          busy_q, busy_d;
  logic [8:0]    t_q, t_d, sck_end;
  logic [2:0]    wait_q, wait_d;
  logic [103:0]  tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic [23:0]   id_reg_q, id_reg_d;
  logic [31:0]   boot_word_q, boot_word_d;
  logic          sck_q, sck_d, sdo_q, sdo_d;
  logic          csn0_q, csn0_d, csn1_q, csn1_d;
  logic [1:0]    mode_q, mode_d;

  assign rst_all_n = rst_n & pwrup_rst_n & cpu_rst_n;

  // Reset synchronizer: asserts immediately, releases two clocks after the inputs.
  always_ff @(posedge clk or negedge rst_all_n) begin
    if (!rst_all_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Two-flop synchronizers plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      rtc_sync_q  <= '0;
      ext_sync_q  <= '0;
      soft_sync_q <= '0;
    end else begin
      rtc_sync_q  <= {rtc_sync_q[1:0], rtc_clk};
      ext_sync_q  <= {ext_sync_q[1:0], ext_irq};
      soft_sync_q <= {soft_sync_q[1:0], soft_irq};
    end
  end

  assign rtc_edge  = rtc_sync_q[1]  & ~rtc_sync_q[2];
  assign ext_edge  = ext_sync_q[1]  & ~ext_sync_q[2];
  assign soft_edge = soft_sync_q[1] & ~soft_sync_q[2];

  // RTC tick counter and pending flags; an edge landing on frame entry is kept for the next frame.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      rtc_cnt_q   <= '0;
      pend_ext_q  <= 1'b0;
      pend_soft_q <= 1'b0;
    end else begin
      if (rtc_edge) rtc_cnt_q <= rtc_cnt_q + 32'd1;
      pend_ext_q  <= (pend_ext_q  & ~frame_start) | ext_edge;
      pend_soft_q <= (pend_soft_q & ~frame_start) | soft_edge;
    end
  end

  // Sequencer state and registered SPI outputs.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q     <= ST_RST_WAIT;
      busy_q      <= 1'b0;
      t_q         <= '0;
      wait_q      <= 3'd3;
      tx_q        <= '0;
      rx_q        <= '0;
      id_reg_q    <= '0;
      boot_word_q <= '0;
      sck_q       <= 1'b0;
      sdo_q       <= 1'b0;
      csn0_q      <= 1'b1;
      csn1_q      <= 1'b1;
      mode_q      <= MODE_SINGLE;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      t_q         <= t_d;
      wait_q      <= wait_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      id_reg_q    <= id_reg_d;
      boot_word_q <= boot_word_d;
      sck_q       <= sck_d;
      sdo_q       <= sdo_d;
      csn0_q      <= csn0_d;
      csn1_q      <= csn1_d;
      mode_q      <= mode_d;
    end
  end

  // Next-state logic. t_q counts clocks since CS fell: bit period b spans t = 4b..4b+3,
  // SCK is high for the upper half, the last falling edge comes at t = 4N and CS rises two clocks later.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    t_d         = t_q;
    wait_d      = (wait_q != 3'd0) ? wait_q - 3'd1 : 3'd0;
    tx_d        = tx_q;
    rx_d        = rx_q;
    id_reg_d    = id_reg_q;
    boot_word_d = boot_word_q;
    sck_d       = sck_q;
    sdo_d       = sdo_q;
    csn0_d      = csn0_q;
    csn1_d      = csn1_q;
    mode_d      = mode_q;
    frame_start = 1'b0;

    case (state_q)
      ST_ID_RD:   sck_end = 9'd128;
      ST_BOOT_RD: sck_end = 9'd192;
      default:    sck_end = 9'd416;
    endcase

    case (state_q)
      ST_RST_WAIT: begin
        if (wait_q == 3'd0) begin
          state_d = ST_ID_RD;
          busy_d  = 1'b1;
          t_d     = '0;
          csn0_d  = 1'b0;
          tx_d    = {8'h9F, 96'd0};
        end
      end
      ST_BOOT_RD: begin
        if (!busy_q && wait_q == 3'd0) begin
          busy_d = 1'b1;
          t_d    = '0;
          csn0_d = 1'b0;
          tx_d   = {8'h6B, 96'd0};
        end
      end
      ST_RUN: begin
        if ((pend_ext_q | pend_soft_q) && wait_q == 3'd0) begin
          state_d     = ST_FRAME;
          busy_d      = 1'b1;
          t_d         = '0;
          csn1_d      = 1'b0;
          frame_start = 1'b1;
          tx_d        = {6'b101000, pend_soft_q, pend_ext_q, fuse_mhartid, boot_word_q, rtc_cnt_q};
        end
      end
      default: ;
    endcase

    if (busy_q) begin
      t_d = t_q + 9'd1;
      if (t_q < sck_end) begin
        sck_d = t_q[1];
        if (t_q[1:0] == 2'd0) begin
          sdo_d = tx_q[103];
          tx_d  = {tx_q[102:0], 1'b0};
          // bit 40 of the boot read is the first quad data nibble
          if (state_q == ST_BOOT_RD && t_q == 9'd160) mode_d = MODE_QUAD;
        end
        if (t_q[1:0] == 2'd2) begin
          rx_d = (mode_q == MODE_QUAD) ? {rx_q[27:0], spim_sdi} : {rx_q[30:0], spim_sdi[1]};
        end
      end else if (t_q == sck_end) begin
        sck_d = 1'b0;
        sdo_d = 1'b0;
      end else if (t_q == sck_end + 9'd2) begin
        busy_d = 1'b0;
        csn0_d = 1'b1;
        csn1_d = 1'b1;
        mode_d = MODE_SINGLE;
        wait_d = 3'd7;
        case (state_q)
          ST_ID_RD: begin
            state_d  = ST_BOOT_RD;
            id_reg_d = rx_q[23:0];
          end
          ST_BOOT_RD: begin
            state_d     = ST_RUN;
            boot_word_d = rx_q;
          end
          default: state_d = ST_RUN;
        endcase
      end
    end
  end

  assign spim_clk  = sck_q;
  assign spim_csn0 = csn0_q;
  assign spim_csn1 = csn1_q;
  assign spim_csn2 = 1'b1;
  assign spim_csn3 = 1'b1;
  assign spim_mode = mode_q;
  assign spim_sdo  = {3'b000, sdo_q};

endmodule

// File: tb/tb_pyfive_digital_core.sv
// Directed bench for pyfive_digital_core with a small SPI flash model and a bus monitor.
module tb_pyfive_digital_core;

  logic        clk;
  logic        rst_n, pwrup_rst_n, cpu_rst_n;
  logic        rtc_clk, ext_irq, soft_irq;
  logic [31:0] fuse_mhartid;
  logic        spim_clk, spim_csn0, spim_csn1, spim_csn2, spim_csn3;
  logic [1:0]  spim_mode;
  logic [3:0]  spim_sdi, spim_sdo;

  int n_checks = 0;
  int n_errors = 0;

  // flash contents, set by the stimulus thread
  logic [23:0] id_val;
  logic [31:0] boot_val;

  // monitor state, written only by the monitor block
  logic        prev_csn0 = 1'b1, prev_csn1 = 1'b1, prev_sck = 1'b0;
  int          cs0_idx = 0, cur_sck = 0, cur_quad = 0, cur_len = 0;
  logic [103:0] cur_mosi = '0;
  logic [31:0] id_mosi = '0;
  logic [47:0] boot_mosi = '0;
  int          id_sck = 0, boot_sck = 0, boot_quad = 0;
  logic [103:0] last_frame = '0;
  int          frame_len = 0, frame_sck = 0, frame_cnt = 0;
  int          gap_cnt = 0, min_gap = 1000;
  logic        had_txn = 1'b0, cs23_low = 1'b0;

  pyfive_digital_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwrup_rst_n  (pwrup_rst_n),
    .cpu_rst_n    (cpu_rst_n),
    .rtc_clk      (rtc_clk),
    .fuse_mhartid (fuse_mhartid),
    .ext_irq      (ext_irq),
    .soft_irq     (soft_irq),
    .spim_clk     (spim_clk),
    .spim_csn0    (spim_csn0),
    .spim_csn1    (spim_csn1),
    .spim_csn2    (spim_csn2),
    .spim_csn3    (spim_csn3),
    .spim_mode    (spim_mode),
    .spim_sdi     (spim_sdi),
    .spim_sdo     (spim_sdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus monitor and flash model, evaluated away from the active clock edge.
  always @(negedge clk) begin
    if (!(rst_n && pwrup_rst_n && cpu_rst_n)) begin
      cs0_idx  = 0;
      had_txn  = 1'b0;
      gap_cnt  = 0;
      cur_sck  = 0;
      cur_quad = 0;
      cur_len  = 0;
      cur_mosi = '0;
      spim_sdi = 4'h0;
    end else begin
      if ((!spim_csn0 || !spim_csn1) && prev_csn0 && prev_csn1) begin
        if (had_txn && gap_cnt < min_gap) min_gap = gap_cnt;
        cur_sck  = 0;
        cur_quad = 0;
        cur_len  = 0;
        cur_mosi = '0;
      end
      if (spim_csn0 && spim_csn1) gap_cnt++;
      else gap_cnt = 0;
      if (!spim_csn0 || !spim_csn1) cur_len++;
      if (spim_clk && !prev_sck && (!spim_csn0 || !spim_csn1)) begin
        cur_mosi = {cur_mosi[102:0], spim_sdo[0]};
        cur_sck++;
        if (spim_mode == 2'b10) cur_quad++;
      end
      if (spim_csn0 && !prev_csn0) begin
        if (cs0_idx == 0) begin
          id_mosi = cur_mosi[31:0];
          id_sck  = cur_sck;
        end else begin
          boot_mosi = cur_mosi[47:0];
          boot_sck  = cur_sck;
          boot_quad = cur_quad;
        end
        cs0_idx++;
        had_txn = 1'b1;
      end
      if (spim_csn1 && !prev_csn1) begin
        last_frame = cur_mosi;
        frame_len  = cur_len;
        frame_sck  = cur_sck;
        frame_cnt++;
        had_txn = 1'b1;
      end
      spim_sdi = 4'h0;
      if (!spim_csn0) begin
        if (cs0_idx == 0 && cur_sck >= 8 && cur_sck < 32)
          spim_sdi[1] = id_val[31 - cur_sck];
        else if (cs0_idx == 1 && cur_sck >= 40 && cur_sck < 48)
          spim_sdi = boot_val[(47 - cur_sck) * 4 +: 4];
      end
    end
    if (!spim_csn2 || !spim_csn3) cs23_low = 1'b1;
    prev_csn0 = spim_csn0;
    prev_csn1 = spim_csn1;
    prev_sck  = spim_clk;
  end

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_cnt >= target) break;
    end
    chk("frame_wait", frame_cnt >= target, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rtc(input int n);
    for (int i = 0; i < n; i++) begin
      rtc_clk = 1'b1;
      idle(4);
      rtc_clk = 1'b0;
      idle(4);
    end
  endtask

  initial begin
    int k;
    int fc;
    rst_n        = 1'b0;
    pwrup_rst_n  = 1'b1;
    cpu_rst_n    = 1'b1;
    rtc_clk      = 1'b0;
    ext_irq      = 1'b0;
    soft_irq     = 1'b0;
    fuse_mhartid = 32'h0000_0005;
    id_val       = 24'h012018;
    boot_val     = 32'hDEAD_BEEF;

    idle(5);
    chk("reset_outputs", {spim_csn3, spim_csn2, spim_csn1, spim_csn0, spim_clk, spim_mode, spim_sdo},
        11'b1111_0_00_0000);

    // boot: first SCK rise 2 (reset sync) + 7 clocks after release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      k = i;
      if (spim_clk) break;
    end
    chk("boot_sck_lat", k, 9);

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cs0_idx >= 2) break;
    end
    chk("boot_done", cs0_idx, 2);
    chk("id_mosi", id_mosi, 32'h9F00_0000);
    chk("id_sck", id_sck, 32);
    chk("id_reg", dut.id_reg_q, 24'h012018);
    chk("boot_mosi", boot_mosi, 48'h6B00_0000_0000);
    chk("boot_sck", boot_sck, 48);
    chk("boot_quad_sck", boot_quad, 8);
    chk("mode_after_boot", spim_mode, 2'b00);

    // ext_irq frame after 10 rtc ticks
    pulse_rtc(10);
    idle(10);
    @(posedge clk);
    #1;
    ext_irq = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      k = i;
      if (!spim_csn1) break;
    end
    chk("irq_latency_le5", k <= 5, 1'b1);
    wait_frames(1, 600);
    chk("frame1_data", last_frame, {8'hA1, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0000_000A});
    chk("frame1_len", frame_len, 419);
    chk("frame1_sck", frame_sck, 104);
    ext_irq = 1'b0;
    idle(20);

    // simultaneous edges, then a soft pulse in the middle of that frame
    ext_irq  = 1'b1;
    soft_irq = 1'b1;
    idle(4);
    ext_irq  = 1'b0;
    soft_irq = 1'b0;
    idle(150);
    soft_irq = 1'b1;
    idle(4);
    soft_irq = 1'b0;
    wait_frames(2, 1000);
    chk("frame2_data", last_frame, {8'hA3, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0000_000A});
    wait_frames(3, 1000);
    chk("frame3_data", last_frame, {8'hA2, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0000_000A});
    chk("frame3_len", frame_len, 419);
    chk("gap_before_frame3", min_gap >= 8, 1'b1);
    idle(20);

    // reset in the middle of byte 4 of a frame
    fc = frame_cnt;
    ext_irq = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!spim_csn1 && cur_sck >= 34) break;
    end
    chk("reached_byte4", (!spim_csn1 && cur_sck >= 34), 1'b1);
    cpu_rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs",
        {spim_csn3, spim_csn2, spim_csn1, spim_csn0, spim_clk, spim_mode, spim_sdo}, 11'b1111_0_00_0000);
    idle(5);
    ext_irq  = 1'b0;
    id_val   = 24'hC28017;
    boot_val = 32'hCAFE_F00D;
    @(negedge clk);
    cpu_rst_n = 1'b1;
    idle(5);

    // three ext pulses and 3 rtc ticks while boot reruns
    for (int i = 0; i < 3; i++) begin
      ext_irq = 1'b1;
      idle(4);
      ext_irq = 1'b0;
      idle(4);
    end
    pulse_rtc(3);
    wait_frames(fc + 1, 2000);
    chk("frame4_data", last_frame, {8'hA1, 32'h0000_0005, 32'hCAFE_F00D, 32'h0000_0003});
    chk("frame4_len", frame_len, 419);
    chk("id_reg_reboot", dut.id_reg_q, 24'hC28017);
    idle(600);
    chk("merged_single_frame", frame_cnt, fc + 1);
    chk("cs_gap_min8", min_gap >= 8, 1'b1);
    chk("csn23_high", cs23_low, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pyfive_digital_core.md
# pyfive_digital_core

SPI-master boot and status sequencer forming the digital core of the pyfive chip top (`digital_core`).
- After reset it identifies and reads the first boot word from the external quad SPI flash on chip-select 0.
- It then sends status frames on chip-select 1 whenever an external or software interrupt edge occurs.
- It keeps a free-running count of `rtc_clk` ticks, sampled into the `clk` domain.

## Interface
Parameters: none (all constants are fixed below).

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; sole clock of the block.
- `rst_n`  in  1  asynchronous active-low reset.
- `pwrup_rst_n`  in  1  power-up reset, asynchronous active-low; ANDed with `rst_n`.
- `cpu_rst_n`  in  1  core reset, asynchronous active-low; ANDed with `rst_n`.
- `rtc_clk`  in  1  slow tick input; treated as data, never as a clock.
- `fuse_mhartid`  in  32  hart ID, sent in status frames.
- `ext_irq`  in  1  external interrupt, asynchronous level.
- `soft_irq`  in  1  software interrupt, asynchronous level.
- `spim_clk`  out  1  SPI SCK, CPOL=0.
- `spim_csn0`  out  1  flash chip select, active low.
- `spim_csn1`  out  1  status-frame chip select, active low.
- `spim_csn2`, `spim_csn3`  out  1 each  held high.
- `spim_mode`  out  2  bus mode: 00 single, 10 quad-in; 01 and 11 unused.
- `spim_sdi`  in  4  SPI data in. Single mode samples bit 1 (MISO); quad mode samples [3:0].
- `spim_sdo`  out  4  SPI data out. Single mode drives bit 0 (MOSI); bits [3:1] are driven 0.

## Operation
- **Internal reset:** `rst_n & pwrup_rst_n & cpu_rst_n`, asynchronous assert and synchronous deassert via a 2-flop synchronizer.
- **Reset outputs:** all csn = 1, `spim_clk` = 0, `spim_sdo` = 0, `spim_mode` = 00.
- **Synchronizers:** `rtc_clk`, `ext_irq` and `soft_irq` each pass through a 2-flop synchronizer, followed by a rising-edge detect.
- **RTC counter:** 32 bits, counts synchronized `rtc_clk` rising edges and wraps at 2^32.
- **State machine:** RST_WAIT → ID_RD → BOOT_RD → RUN ⇄ FRAME.
- **RST_WAIT:** wait 4 clk after internal reset deasserts.
- **ID_RD (CS0, single mode):**
  - Send 0x9F, then read 3 bytes into `id_reg[23:0]`, first byte received lands in [23:16].
  - 32 SCK total.
- **BOOT_RD (CS0):**
  - Send 0x6B, then address 0x000000 MSB first, both in single mode.
  - Then 8 dummy SCK with `spim_sdo` = 0.
  - Then `spim_mode` = 10 and read 8 nibbles into `boot_word[31:0]`, high nibble first.
  - 48 SCK total; `spim_mode` returns to 00 when CS0 rises.
- **Pending flags:** an ext_irq edge sets `pend_ext`, a soft_irq edge sets `pend_soft`. Edges are captured in every state, including during boot.
- **RUN:** if any pending flag is set, enter FRAME; pending flags are cleared on entry.
- **FRAME (CS1, single mode):** 13 bytes, MSB first, 104 SCK:
  - byte 0: `{6'b101000, pend_soft, pend_ext}`, flag values as captured at entry;
  - bytes 1–4: `fuse_mhartid`;
  - bytes 5–8: `boot_word`;
  - bytes 9–12: RTC counter.
  - All fields are snapshotted at FRAME entry.
- **Simultaneous events:** both edges in the same cycle give one frame with byte 0 = 0xA3.
- **Events during a frame:** edges arriving during a frame set flags for the next frame.
- **Repeated edges:** multiple edges of one source before a frame starts merge into one flag.
- **Reset mid-transaction:** outputs return to their reset values immediately; flags, `id_reg`, `boot_word` and the RTC counter clear; boot reruns after release.

## Timing
- **SPI mode 0, bit period 4 clk:**
  - clk 0–1: SCK low, `spim_sdo` updates at the start of clk 0;
  - clk 2–3: SCK high;
  - `spim_sdi` is sampled on the clk edge where SCK rises.
- **CS setup:** CS falls 1 clk before the first bit period.
- **CS hold:** CS rises 2 clk after the last SCK falling edge.
- **CS gap:** minimum 8 clk high between any two transactions, including ID_RD → BOOT_RD and back-to-back frames.
- **Boot to first SCK:** first SCK rising edge is 4+1+2 = 7 clk after internal reset deassertion.
- **Interrupt latency (RUN idle):** synchronizer (2) + edge detect (1) + FRAME entry (1) → CS1 falls ≤ 5 clk after the input rises.
- **Frame length:** 104×4 + 3 = 419 clk from CS1 fall to CS1 rise.
- **Output registers:** all SPI outputs are registered and glitch-free.

## Test plan
- **Reset/boot:**
  - Check during reset: csn* = 1, SCK = 0, `spim_mode` = 00.
  - After release, flash model returns ID 0x012018: expect 32 SCK on CS0 with MOSI carrying 0x9F, then CS0 high ≥ 8 clk.
- **Quad boot read:** flash returns nibbles 0xDEADBEEF. Expect opcode 0x6B, address 0, 8 dummy SCK, `spim_mode` = 10 for exactly 8 SCK, and `boot_word` = 0xDEADBEEF.
- **ext_irq frame:**
  - Inputs: `fuse_mhartid` = 0x00000005 and 10 rtc edges before ext_irq rises.
  - Expect on CS1: A1 00000005 DEADBEEF 0000000A, 419 clk long.
- **Simultaneous interrupts:**
  - ext_irq and soft_irq rise in the same cycle → single frame, byte 0 = 0xA3.
  - soft_irq pulse mid-frame → second frame with byte 0 = 0xA2, starting ≥ 8 clk after CS1 rises.
- **Reset mid-frame:** assert `cpu_rst_n` = 0 during byte 4 → CS1 high and SCK 0 immediately; after release the boot sequence repeats and the RTC counter restarts at 0.
- **Edge merging and idle selects:** three ext_irq pulses before RUN → one frame with byte 0 = 0xA1; `spim_csn2` and `spim_csn3` stay high throughout.
